// File: rtl/i2s_pkg.sv
// Shared constants for the I2S DAC transmitter.
// Build option: define I2S_TX_LEFT_JUSTIFIED_EN for left-justified slot format.
package i2s_pkg;

  localparam int DATA_W_DEF = 24;
  localparam int SLOT_W_DEF = 32;
  localparam int FRAME_BITS = 2 * SLOT_W_DEF;

`ifdef I2S_TX_LEFT_JUSTIFIED_EN
  localparam int SLOT_OFS = 0;
`else
  localparam int SLOT_OFS = 1;
`endif

  function automatic int frame_bits(input int slot_w);
    return 2 * slot_w;
  endfunction

endpackage

// File: rtl/i2s_dac_tx_if.sv
// Sample-pair handshake between the processing chain and the I2S transmitter.
interface i2s_dac_tx_if #(
  parameter int DATA_W = i2s_pkg::DATA_W_DEF
);
  logic [DATA_W-1:0] l_data_in;
  logic [DATA_W-1:0] r_data_in;
  logic              in_valid;
  logic              in_ready;

  modport master (output l_data_in, output r_data_in, output in_valid, input in_ready);
  modport slave  (input l_data_in, input r_data_in, input in_valid, output in_ready);
endinterface

// File: rtl/i2s_clk_gen.sv
// Bit/word clock generator: bclk divider, falling-edge strobe, frame bit counter, lrclk.
module i2s_clk_gen
  import i2s_pkg::*;
#(
  parameter int SLOT_W   = SLOT_W_DEF,
  parameter int BCLK_DIV = 4,
  localparam int CW      = $clog2(frame_bits(SLOT_W))
) (
  input  logic          clk,
  input  logic          reset_n,
  output logic          bclk_o,
  output logic          lrclk_o,
  output logic          fall_o,
  output logic [CW-1:0] bit_nxt_o
);

  localparam int HALF = BCLK_DIV / 2;
  localparam int DW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int FB   = frame_bits(SLOT_W);

  logic [DW-1:0] div_q, div_d;
  logic          bclk_q;
  logic [CW-1:0] bit_q;
  logic          lr_q;
  logic          tc;

  // fall_o and bit_nxt_o describe the edge about to happen, so the top can act in the same cycle
  always_comb begin
    tc        = (div_q == DW'(HALF - 1));
    div_d     = tc ? '0 : div_q + DW'(1);
    fall_o    = tc & bclk_q;
    bit_nxt_o = (bit_q == CW'(FB - 1)) ? '0 : bit_q + CW'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q  <= '0;
      bclk_q <= 1'b0;
      bit_q  <= CW'(FB - 1);
      lr_q   <= 1'b0;
    end else begin
      div_q <= div_d;
      if (tc) bclk_q <= ~bclk_q;
      if (fall_o) begin
        bit_q <= bit_nxt_o;
        lr_q  <= (bit_nxt_o >= CW'(SLOT_W));
      end
    end
  end

  assign bclk_o  = bclk_q;
  assign lrclk_o = lr_q;

endmodule

// File: rtl/i2s_dac_tx.sv
// I2S DAC transmitter: holding register, per-channel shift registers and handshake.
// Build option: I2S_TX_LEFT_JUSTIFIED_EN selects left-justified instead of one-bit-delay I2S.
module i2s_dac_tx
  import i2s_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int SLOT_W   = SLOT_W_DEF,
  parameter int BCLK_DIV = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  i2s_dac_tx_if.slave   s_if,
  output logic          ac_bclk,
  output logic          ac_lrclk,
  output logic          ac_dac_sdata,
  output logic          frame_start,
  output logic          underrun
);

  localparam int CW = $clog2(frame_bits(SLOT_W));

  logic              fall;
  logic [CW-1:0]     bit_nxt;
  logic [CW-1:0]     pos_w;
  int                bitpos;
  logic              right, in_rng, load, accept;
  logic [DATA_W-1:0] hold_l_q, hold_r_q;
  logic [DATA_W-1:0] l_sh_q, l_sh_d, r_sh_q, r_sh_d, l_cur, r_cur;
  logic              hold_full_q, hold_full_d;
  logic              in_ready_q, sdata_q, sdata_d, fs_q, ur_q;

  i2s_clk_gen #(
    .SLOT_W  (SLOT_W),
    .BCLK_DIV(BCLK_DIV)
  ) u_clk_gen (
    .clk      (clk),
    .reset_n  (reset_n),
    .bclk_o   (ac_bclk),
    .lrclk_o  (ac_lrclk),
    .fall_o   (fall),
    .bit_nxt_o(bit_nxt)
  );

  always_comb begin
    right  = (bit_nxt >= CW'(SLOT_W));
    pos_w  = right ? bit_nxt - CW'(SLOT_W) : bit_nxt;
    bitpos = int'(pos_w) - SLOT_OFS;
    in_rng = (bitpos >= 0) && (bitpos < DATA_W);
    load   = fall && (bit_nxt == '0);
    accept = s_if.in_valid && in_ready_q;

    // On a load the fresh word is used directly so a bit at slot position 0 comes from it
    l_cur = l_sh_q;
    r_cur = r_sh_q;
    if (load) begin
      l_cur = hold_full_q ? hold_l_q : '0;
      r_cur = hold_full_q ? hold_r_q : '0;
    end

    l_sh_d  = l_cur;
    r_sh_d  = r_cur;
    sdata_d = 1'b0;
    if (in_rng) begin
      if (right) begin
        sdata_d = r_cur[DATA_W-1];
        r_sh_d  = r_cur << 1;
      end else begin
        sdata_d = l_cur[DATA_W-1];
        l_sh_d  = l_cur << 1;
      end
    end

    // A pair accepted during a load that found holding empty waits for the next frame
    hold_full_d = hold_full_q;
    if (load)   hold_full_d = 1'b0;
    if (accept) hold_full_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_l_q    <= '0;
      hold_r_q    <= '0;
      hold_full_q <= 1'b0;
      in_ready_q  <= 1'b1;
      l_sh_q      <= '0;
      r_sh_q      <= '0;
      sdata_q     <= 1'b0;
      fs_q        <= 1'b0;
      ur_q        <= 1'b0;
    end else begin
      hold_full_q <= hold_full_d;
      in_ready_q  <= ~hold_full_d;
      if (accept) begin
        hold_l_q <= s_if.l_data_in;
        hold_r_q <= s_if.r_data_in;
      end
      if (fall) begin
        l_sh_q  <= l_sh_d;
        r_sh_q  <= r_sh_d;
        sdata_q <= sdata_d;
      end
      fs_q <= load;
      ur_q <= load & ~hold_full_q;
    end
  end

  assign s_if.in_ready = in_ready_q;
  assign ac_dac_sdata  = sdata_q;
  assign frame_start   = fs_q;
  assign underrun      = ur_q;

endmodule

// File: tb/tb_i2s_dac_tx.sv
// Scoreboard bench for i2s_dac_tx: randomized and directed pairs against a frame-level model.
module tb_i2s_dac_tx;

  localparam int DW   = 24;
  localparam int SW   = 32;
  localparam int BD   = 4;
  localparam int FB   = 2 * SW;
  localparam int FCLK = FB * BD;
`ifdef I2S_TX_LEFT_JUSTIFIED_EN
  localparam int OFS = 0;
`else
  localparam int OFS = 1;
`endif

  typedef struct {
    int          k;
    logic [DW-1:0] l;
    logic [DW-1:0] r;
    logic        mute;
  } frame_t;

  typedef struct {
    int          k;
    logic [DW-1:0] l;
    logic [DW-1:0] r;
  } offer_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic ac_bclk, ac_lrclk, ac_dac_sdata, frame_start, underrun;

  i2s_dac_tx_if #(.DATA_W(DW)) bus ();

  i2s_dac_tx #(
    .DATA_W  (DW),
    .SLOT_W  (SW),
    .BCLK_DIV(BD)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .s_if        (bus.slave),
    .ac_bclk     (ac_bclk),
    .ac_lrclk    (ac_lrclk),
    .ac_dac_sdata(ac_dac_sdata),
    .frame_start (frame_start),
    .underrun    (underrun)
  );

  always #5 clk = ~clk;

  frame_t expq[$];
  offer_t dirq[$];
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int permil = 0;
  logic          m_full = 1'b0;
  logic [DW-1:0] m_hl = '0, m_hr = '0;
  logic          offering = 1'b0;
  logic [DW-1:0] o_l = '0, o_r = '0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic add_offer(input int k, input logic [DW-1:0] l, input logic [DW-1:0] r);
    offer_t o;
    o.k = k; o.l = l; o.r = r;
    dirq.push_back(o);
  endtask

  // first frame-load edge strictly after edge number c (edges counted from reset release)
  function automatic int next_load(input int c);
    if (c + 1 <= 4) return 4;
    return 4 + ((c + 1 - 4 + FCLK - 1) / FCLK) * FCLK;
  endfunction

  // Drives the source and keeps the frame-level model; called at a negedge, returns at one.
  task automatic run_stim(input int last_k);
    int     k;
    logic   rdy;
    frame_t f;
    while (cyc < last_k) begin
      k = cyc + 1;
      chk("in_ready", 64'(bus.in_ready), 64'(!m_full));
      if (!offering) begin
        if (dirq.size() > 0 && dirq[0].k <= k) begin
          offering = 1'b1; o_l = dirq[0].l; o_r = dirq[0].r;
          void'(dirq.pop_front());
        end else if (permil > 0 && int'($urandom_range(999)) < permil) begin
          offering = 1'b1; o_l = DW'($urandom); o_r = DW'($urandom);
        end
      end
      bus.in_valid  = offering;
      bus.l_data_in = o_l;
      bus.r_data_in = o_r;
      rdy = !m_full;
      if (k >= 4 && (k - 4) % FCLK == 0) begin
        f.k = k;
        f.mute = !m_full;
        f.l = m_full ? m_hl : '0;
        f.r = m_full ? m_hr : '0;
        expq.push_back(f);
        m_full = 1'b0;
      end
      if (offering && rdy) begin
        m_hl = o_l; m_hr = o_r; m_full = 1'b1; offering = 1'b0;
      end
      @(posedge clk);
      cyc = k;
      @(negedge clk);
    end
  endtask

  task automatic run_mon(input int nf);
    frame_t      e;
    int          wait_n, fs_n, ur_n, bclk_bad, ch_j;
    logic [DW-1:0] ch;
    logic [63:0] exp_sd, exp_lr, got_sd, got_lr;
    for (int f = 0; f < nf; f++) begin
      wait_n = 0;
      while (!frame_start && wait_n < 300) begin
        @(negedge clk);
        wait_n++;
      end
      if (!frame_start) begin
        chk("frame_start_timeout", 64'd0, 64'd1);
        return;
      end
      if (expq.size() == 0) begin
        chk("unexpected_frame", 64'd0, 64'd1);
        return;
      end
      e = expq.pop_front();
      chk("load_cycle", 64'(cyc), 64'(e.k));
      chk("underrun_at_load", 64'(underrun), 64'(e.mute));
      for (int n = 0; n < FB; n++) begin
        ch   = (n >= SW) ? e.r : e.l;
        ch_j = (n % SW) - OFS;
        exp_sd[n] = (ch_j >= 0 && ch_j < DW) ? ch[DW-1-ch_j] : 1'b0;
        exp_lr[n] = (n >= SW);
      end
      fs_n = 0; ur_n = 0; bclk_bad = 0;
      got_sd = '0; got_lr = '0;
      for (int j = 0; j < FCLK; j++) begin
        if (j > 0) @(negedge clk);
        fs_n += int'(frame_start);
        ur_n += int'(underrun);
        if (ac_bclk !== ((j % BD) >= BD / 2)) bclk_bad++;
        if (j % BD == 0) begin
          got_sd[j/BD] = ac_dac_sdata;
          got_lr[j/BD] = ac_lrclk;
        end
      end
      chk("sdata_frame", got_sd, exp_sd);
      chk("lrclk_frame", got_lr, exp_lr);
      chk("frame_start_count", 64'(fs_n), 64'd1);
      chk("underrun_count", 64'(ur_n), 64'(e.mute));
      chk("bclk_shape", 64'(bclk_bad), 64'd0);
    end
  endtask

  task automatic run_phase(input int nf);
    int last;
    last = next_load(cyc) + FCLK * nf - 1;
    fork
      run_stim(last);
      run_mon(nf);
    join
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    chk("reset_async_outputs",
        64'({ac_bclk, ac_lrclk, ac_dac_sdata, bus.in_ready, frame_start, underrun}), 64'b000100);
    repeat (3) @(negedge clk);
    chk("reset_held_outputs",
        64'({ac_bclk, ac_lrclk, ac_dac_sdata, bus.in_ready, frame_start, underrun}), 64'b000100);
    reset_n  = 1'b1;
    cyc      = 0;
    m_full   = 1'b0;
    offering = 1'b0;
    expq.delete();
    dirq.delete();
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.l_data_in = '0;
    bus.r_data_in = '0;
    do_reset();

    add_offer(1, 24'hA5A5A5, 24'h5A5A5A);
    run_phase(3);

    run_phase(2);

    add_offer(cyc + 10, 24'h111111, 24'h222222);
    add_offer(cyc + 11, 24'h333333, 24'h444444);
    run_phase(3);

    add_offer(cyc + 5, 24'h800001, 24'h7FFFFF);
    permil = 3;
    run_phase(6);
    permil = 0;

    // pending pair sitting in holding, reset lands at bit_cnt 40
    add_offer(cyc + 2, 24'h123456, 24'h654321);
    run_stim(cyc + 162);
    do_reset();

    add_offer(4, 24'hC0FFEE, 24'h0BEEF1);
    run_phase(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
